// File: rtl/rocc_latency_model.sv
// RoCC accelerator latency model: queues commands in a small FIFO and
// answers each one after a configurable, class-dependent execution delay.
module rocc_latency_model #(
    parameter int XLEN         = 64,
    parameter int CMD_DEPTH    = 4,
    parameter int BASE_LATENCY = 500,
    parameter int LAT_STEP     = 100
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_cmd_valid,
    output logic            io_cmd_ready,
    input  logic [6:0]      io_cmd_bits_inst_funct,
    input  logic [4:0]      io_cmd_bits_inst_rd,
    input  logic [XLEN-1:0] io_cmd_bits_rs1,
    input  logic [XLEN-1:0] io_cmd_bits_rs2,
    input  logic            io_resp_ready,
    output logic            io_resp_valid,
    output logic [4:0]      io_resp_bits_rd,
    output logic [XLEN-1:0] io_resp_bits_data,
    output logic            io_busy
);

    localparam int PW      = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW      = PW + 1;
    localparam int CDW_RAW = $clog2(BASE_LATENCY + 3 * LAT_STEP + 1);
    localparam int CDW     = (CDW_RAW < 1) ? 1 : CDW_RAW;

    localparam logic [CW-1:0]  DEPTH_C = CW'(CMD_DEPTH);
    localparam logic [CDW-1:0] LAT0 = CDW'(BASE_LATENCY);
    localparam logic [CDW-1:0] LAT1 = CDW'(BASE_LATENCY + LAT_STEP);
    localparam logic [CDW-1:0] LAT2 = CDW'(BASE_LATENCY + 2 * LAT_STEP);
    localparam logic [CDW-1:0] LAT3 = CDW'(BASE_LATENCY + 3 * LAT_STEP);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [3:0]      fn_mem  [CMD_DEPTH];
    logic [4:0]      rd_mem  [CMD_DEPTH];
    logic [XLEN-1:0] rs1_mem [CMD_DEPTH];
    logic [XLEN-1:0] rs2_mem [CMD_DEPTH];

    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      state_q, state_d;
    logic [CDW-1:0]  cd_q, cd_d;
    logic [31:0]     done_q, done_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      crd_q, crd_d;
    logic [XLEN-1:0] crs1_q, crs1_d, crs2_q, crs2_d;
    logic [4:0]      rrd_q, rrd_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic            push, pop;
    logic [3:0]      head_fn;
    logic [CDW-1:0]  lat_sel;
    logic [XLEN-1:0] result;
    logic            unused_funct;

    assign unused_funct = ^io_cmd_bits_inst_funct[6:4];

    // Readiness comes only from the registered count, so a full FIFO
    // stays closed even in a cycle where the engine pops.
    assign io_cmd_ready      = (count_q < DEPTH_C);
    assign push              = io_cmd_valid && io_cmd_ready;
    assign pop               = (state_q == S_IDLE) && (count_q != '0);
    assign head_fn           = fn_mem[rptr_q];
    assign io_resp_valid     = (state_q == S_RESP);
    assign io_resp_bits_rd   = rrd_q;
    assign io_resp_bits_data = rdata_q;
    assign io_busy           = (count_q != '0) || (state_q != S_IDLE);

    // Execution delay for the head entry's latency class.
    always_comb begin
        lat_sel = LAT0;
        unique case (head_fn[1:0])
            2'd0: lat_sel = LAT0;
            2'd1: lat_sel = LAT1;
            2'd2: lat_sel = LAT2;
            2'd3: lat_sel = LAT3;
        endcase
    end

    // Result of the in-flight command.
    always_comb begin
        result = crs1_q;
        unique case (op_q)
            2'd0: result = crs1_q + crs2_q;
            2'd1: result = crs1_q ^ crs2_q;
            2'd2: result = XLEN'(done_q);
            2'd3: result = crs1_q;
        endcase
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Engine FSM: pop, count down, then hold the response until taken.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        done_d  = done_q;
        op_d    = op_q;
        crd_d   = crd_q;
        crs1_d  = crs1_q;
        crs2_d  = crs2_q;
        rrd_d   = rrd_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_EXEC;
                    cd_d    = lat_sel;
                    op_d    = head_fn[3:2];
                    crd_d   = rd_mem[rptr_q];
                    crs1_d  = rs1_mem[rptr_q];
                    crs2_d  = rs2_mem[rptr_q];
                end
            end
            S_EXEC: begin
                if (cd_q == '0) begin
                    state_d = S_RESP;
                    rrd_d   = crd_q;
                    rdata_d = result;
                end else begin
                    cd_d = cd_q - CDW'(1);
                end
            end
            S_RESP: begin
                if (io_resp_ready) begin
                    state_d = S_IDLE;
                    done_d  = done_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            fn_mem[wptr_q]  <= io_cmd_bits_inst_funct[3:0];
            rd_mem[wptr_q]  <= io_cmd_bits_inst_rd;
            rs1_mem[wptr_q] <= io_cmd_bits_rs1;
            rs2_mem[wptr_q] <= io_cmd_bits_rs2;
        end
    end

    // State registers; reset drops every queued and in-flight command.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            state_q <= S_IDLE;
            cd_q    <= '0;
            done_q  <= '0;
            op_q    <= '0;
            crd_q   <= '0;
            crs1_q  <= '0;
            crs2_q  <= '0;
            rrd_q   <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            state_q <= state_d;
            cd_q    <= cd_d;
            done_q  <= done_d;
            op_q    <= op_d;
            crd_q   <= crd_d;
            crs1_q  <= crs1_d;
            crs2_q  <= crs2_d;
            rrd_q   <= rrd_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_rocc_latency_model.sv
// Bench for rocc_latency_model: directed scenarios plus random traffic,
// all checked against a timing/ordering model of the command stream.
module tb_rocc_latency_model;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_cmd_valid = 1'b0;
    logic        io_cmd_ready;
    logic [6:0]  io_cmd_bits_inst_funct = '0;
    logic [4:0]  io_cmd_bits_inst_rd = '0;
    logic [63:0] io_cmd_bits_rs1 = '0;
    logic [63:0] io_cmd_bits_rs2 = '0;
    logic        io_resp_ready = 1'b0;
    logic        io_resp_valid;
    logic [4:0]  io_resp_bits_rd;
    logic [63:0] io_resp_bits_data;
    logic        io_busy;

    always #5 clock = ~clock;

    rocc_latency_model #(
        .XLEN(64), .CMD_DEPTH(4), .BASE_LATENCY(4), .LAT_STEP(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io_cmd_valid(io_cmd_valid),
        .io_cmd_ready(io_cmd_ready),
        .io_cmd_bits_inst_funct(io_cmd_bits_inst_funct),
        .io_cmd_bits_inst_rd(io_cmd_bits_inst_rd),
        .io_cmd_bits_rs1(io_cmd_bits_rs1),
        .io_cmd_bits_rs2(io_cmd_bits_rs2),
        .io_resp_ready(io_resp_ready),
        .io_resp_valid(io_resp_valid),
        .io_resp_bits_rd(io_resp_bits_rd),
        .io_resp_bits_data(io_resp_bits_data),
        .io_busy(io_busy)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        int          lat;
        int          t;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          last_h = -1000;
    int          idx = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          last_rise = -1;
    logic [63:0] last_data = '0;
    logic        prev_v = 1'b0;
    int          n_acc_obs = 0;
    int          n_val_obs = 0;
    int          t0 = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [6:0] f,
                                               input logic [63:0] a,
                                               input logic [63:0] b,
                                               input logic [31:0] n);
        case (f[3:2])
            2'd0:    return a + b;
            2'd1:    return a ^ b;
            2'd2:    return {32'd0, n};
            default: return a;
        endcase
    endfunction

    // One clock cycle: drive inputs, check outputs against the model,
    // then advance the model with this cycle's handshakes.
    task automatic step(input logic v, input logic [6:0] f,
                        input logic [4:0] rd, input logic [63:0] a,
                        input logic [63:0] b, input logic rr);
        int   hp;
        bit   popd;
        bit   ev;
        bit   er;
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        io_cmd_valid           = v;
        io_cmd_bits_inst_funct = f;
        io_cmd_bits_inst_rd    = rd;
        io_cmd_bits_rs1        = a;
        io_cmd_bits_rs2        = b;
        io_resp_ready          = rr;
        @(negedge clock);
        hp   = 0;
        popd = 1'b0;
        ev   = 1'b0;
        if (q.size() != 0) begin
            hp   = (q[0].t > last_h) ? q[0].t + 1 : last_h + 1;
            popd = (hp < cyc);
            ev   = (cyc >= hp + 2 + q[0].lat);
        end
        er = ((q.size() - int'(popd)) < 4);
        check("busy", 64'(io_busy), 64'(q.size() != 0));
        check("cmd_ready", 64'(io_cmd_ready), 64'(er));
        check("resp_valid", 64'(io_resp_valid), 64'(ev));
        if (ev && io_resp_valid) begin
            check("resp_rd", 64'(io_resp_bits_rd), 64'(q[0].rd));
            check("resp_data", io_resp_bits_data, q[0].data);
        end
        if (io_resp_valid && !prev_v) begin
            last_rise = cyc;
            last_data = io_resp_bits_data;
        end
        prev_v = io_resp_valid;
        if (io_resp_valid) n_val_obs++;
        if (v && io_cmd_ready) n_acc_obs++;
        if (ev && rr) begin
            last_h = cyc;
            void'(q.pop_front());
        end
        if (v && er) begin
            e.rd   = rd;
            e.data = ref_result(f, a, b, 32'(idx));
            e.lat  = 4 + 2 * int'(f[1:0]);
            e.t    = cyc;
            q.push_back(e);
            idx++;
        end
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 7'd0, 5'd0, 64'd0, 64'd0, rr);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset         = 1'b0;
        io_cmd_valid  = 1'b0;
        io_resp_ready = 1'b0;
        #1;
        check("rst_valid", 64'(io_resp_valid), 64'd0);
        check("rst_rd", 64'(io_resp_bits_rd), 64'd0);
        check("rst_data", io_resp_bits_data, 64'd0);
        check("rst_ready", 64'(io_cmd_ready), 64'd1);
        check("rst_busy", 64'(io_busy), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        q.delete();
        last_h = -1000;
        idx    = 0;
        prev_v = 1'b0;
    endtask

    initial begin
        do_reset();

        // add, class 0
        last_rise = -1;
        step(1'b1, 7'h00, 5'd3, 64'd5, 64'd6, 1'b1);
        t0 = cyc;
        idle(12, 1'b1);
        check("lat_add", 64'(last_rise - t0), 64'd7);
        check("dat_add", last_data, 64'd11);

        // xor, class 3
        last_rise = -1;
        step(1'b1, 7'h07, 5'd1, 64'hF0, 64'hFF, 1'b1);
        t0 = cyc;
        idle(16, 1'b1);
        check("lat_xor", 64'(last_rise - t0), 64'd13);
        check("dat_xor", last_data, 64'h0F);

        // back-pressure fills the FIFO, then drains in order
        n_acc_obs = 0;
        for (int i = 0; i < 8; i++)
            step(1'b1, 7'h0C, 5'(i + 1), 64'(i * 3), 64'd0, 1'b0);
        check("acc_full", 64'(n_acc_obs), 64'd5);
        idle(60, 1'b1);
        check("busy_drained", 64'(io_busy), 64'd0);

        // done counter readback and add wrap
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 7'h00, 5'(i), 64'(i), 64'd1, 1'b1);
            idle(10, 1'b1);
        end
        step(1'b1, 7'h08, 5'd9, 64'd0, 64'd0, 1'b1);
        idle(10, 1'b1);
        check("done_cnt3", last_data, 64'd3);
        step(1'b1, 7'h00, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        idle(10, 1'b1);
        check("add_wrap", last_data, 64'd0);

        // stalled response with toggling ready
        step(1'b1, 7'h0C, 5'd7, 64'hABCD, 64'd0, 1'b0);
        idle(9, 1'b0);
        for (int i = 0; i < 6; i++)
            step(1'b0, 7'd0, 5'd0, 64'd0, 64'd0, 1'(i % 2));
        idle(3, 1'b1);
        step(1'b1, 7'h08, 5'd2, 64'd0, 64'd0, 1'b1);
        idle(10, 1'b1);
        check("done_cnt6", last_data, 64'd6);

        // reset while executing with two commands queued
        for (int i = 0; i < 3; i++)
            step(1'b1, 7'h03, 5'(i), 64'd1, 64'd2, 1'b0);
        idle(3, 1'b0);
        check("busy_pre", 64'(io_busy), 64'd1);
        do_reset();
        n_val_obs = 0;
        idle(20, 1'b1);
        check("no_resp_after_rst", 64'(n_val_obs), 64'd0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(1, 0)), 7'($urandom),
                 5'($urandom), {$urandom, $urandom},
                 {$urandom, $urandom}, 1'($urandom_range(3, 0) != 0));
        end
        idle(150, 1'b1);
        check("busy_end", 64'(io_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
